// File: rtl/acc_offload_ctrl_if.sv
// ============================================================================
// acc_offload_ctrl_if : core-issue, X-interface and register-file signal bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface acc_offload_ctrl_if #(
  parameter int DataWidth = 32
);
  // Core issue side
  logic                      issue_valid_i;
  logic                      issue_ready_o;
  logic [31:0]               issue_instr_i;
  logic [2:0][DataWidth-1:0] issue_rs_i;
  logic [2:0]                issue_rs_valid_i;
  logic                      issue_accept_o;
  logic                      issue_illegal_o;
  // X-interface request / accept
  logic                      x_q_valid_o;
  logic                      x_q_ready_i;
  logic [31:0]               x_instr_o;
  logic [2:0][DataWidth-1:0] x_rs_o;
  logic [2:0]                x_rs_valid_o;
  logic [1:0]                x_rd_clean_o;
  logic                      x_k_accept_i;
  logic [1:0]                x_k_writeback_i;
  // X-interface response
  logic                      x_p_valid_i;
  logic                      x_p_ready_o;
  logic [4:0]                x_p_rd_i;
  logic [DataWidth-1:0]      x_p_data0_i;
  logic [DataWidth-1:0]      x_p_data1_i;
  logic                      x_p_dual_i;
  logic                      x_p_error_i;
  // Register-file write port
  logic                      wb_valid_o;
  logic                      wb_ready_i;
  logic [4:0]                wb_rd_o;
  logic [DataWidth-1:0]      wb_data_o;
  logic                      wb_error_o;
  logic                      busy_o;

  modport master (
    input  issue_valid_i, issue_instr_i, issue_rs_i, issue_rs_valid_i,
    output issue_ready_o, issue_accept_o, issue_illegal_o,
    output x_q_valid_o, x_instr_o, x_rs_o, x_rs_valid_o, x_rd_clean_o,
    input  x_q_ready_i, x_k_accept_i, x_k_writeback_i,
    input  x_p_valid_i, x_p_rd_i, x_p_data0_i, x_p_data1_i, x_p_dual_i, x_p_error_i,
    output x_p_ready_o,
    output wb_valid_o, wb_rd_o, wb_data_o, wb_error_o, busy_o,
    input  wb_ready_i
  );

  modport slave (
    output issue_valid_i, issue_instr_i, issue_rs_i, issue_rs_valid_i,
    input  issue_ready_o, issue_accept_o, issue_illegal_o,
    input  x_q_valid_o, x_instr_o, x_rs_o, x_rs_valid_o, x_rd_clean_o,
    output x_q_ready_i, x_k_accept_i, x_k_writeback_i,
    output x_p_valid_i, x_p_rd_i, x_p_data0_i, x_p_data1_i, x_p_dual_i, x_p_error_i,
    input  x_p_ready_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, wb_error_o, busy_o,
    output wb_ready_i
  );
endinterface

`default_nettype wire

// File: rtl/acc_offload_ctrl.sv
// ============================================================================
// acc_offload_ctrl : core-side offload controller with rd scoreboard and
//                    dual-writeback sequencing into the register file
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc_offload_ctrl #(
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  acc_offload_ctrl_if.master bus
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic [0:0] {OFF_IDLE = 1'b0, OFF_HOLD = 1'b1} off_state_e;
  typedef enum logic [1:0] {WB_IDLE = 2'd0, WB_D0 = 2'd1, WB_D1 = 2'd2} wb_state_e;

  off_state_e                off_q;
  logic [31:0]               instr_q;
  logic [2:0][DataWidth-1:0] rs_q;
  logic [2:0]                rs_valid_q;
  logic [31:0]               pend_q, pend_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  wb_state_e                 wb_q;
  logic [4:0]                p_rd_q;
  logic [DataWidth-1:0]      p_data0_q, p_data1_q;
  logic                      p_dual_q, p_err_q;

  logic [4:0]  hold_rd, hold_rd1, cur_rd, p_rd1;
  logic        issue_ready, handoff, accept_fire;
  logic        cur_is_x0, step_done, finish;
  logic [31:0] set_mask, clr_mask;

  assign hold_rd     = instr_q[11:7];
  assign hold_rd1    = hold_rd + 5'd1;
  assign p_rd1       = p_rd_q + 5'd1;
  assign issue_ready = (off_q == OFF_IDLE) && (cnt_q < CntW'(MaxOutstanding));
  assign handoff     = (off_q == OFF_HOLD) && bus.x_q_ready_i;
  assign accept_fire = handoff && bus.x_k_accept_i;

  // An x0 step has no register-file write, so it retires without waiting on wb_ready_i.
  assign cur_rd    = (wb_q == WB_D1) ? p_rd1 : p_rd_q;
  assign cur_is_x0 = (cur_rd == 5'd0);
  assign step_done = (wb_q != WB_IDLE) && (bus.wb_ready_i || cur_is_x0);
  assign finish    = step_done && ((wb_q == WB_D1) || !p_dual_q);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (accept_fire) begin
      if (bus.x_k_writeback_i[0] && (hold_rd != 5'd0))  set_mask[hold_rd]  = 1'b1;
      if (bus.x_k_writeback_i[1] && (hold_rd1 != 5'd0)) set_mask[hold_rd1] = 1'b1;
    end
    if (finish) begin
      clr_mask[p_rd_q] = 1'b1;
      if (p_dual_q) clr_mask[p_rd1] = 1'b1;
    end
    pend_d = (pend_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((accept_fire && (bus.x_k_writeback_i != 2'b00)) && !(finish && (cnt_q != '0)))
      cnt_d = cnt_q + CntW'(1);
    else if (!(accept_fire && (bus.x_k_writeback_i != 2'b00)) && finish && (cnt_q != '0))
      cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      off_q      <= OFF_IDLE;
      instr_q    <= '0;
      rs_q       <= '0;
      rs_valid_q <= '0;
    end else begin
      case (off_q)
        OFF_IDLE: begin
          if (bus.issue_valid_i && issue_ready) begin
            instr_q    <= bus.issue_instr_i;
            rs_q       <= bus.issue_rs_i;
            rs_valid_q <= bus.issue_rs_valid_i;
            off_q      <= OFF_HOLD;
          end
        end
        OFF_HOLD: begin
          // Late forwarded operands replace the held copy; validity only accumulates.
          for (int i = 0; i < 3; i++) begin
            if (bus.issue_rs_valid_i[i]) rs_q[i] <= bus.issue_rs_i[i];
          end
          rs_valid_q <= rs_valid_q | bus.issue_rs_valid_i;
          if (bus.x_q_ready_i) off_q <= OFF_IDLE;
        end
        default: off_q <= OFF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_q      <= WB_IDLE;
      p_rd_q    <= '0;
      p_data0_q <= '0;
      p_data1_q <= '0;
      p_dual_q  <= 1'b0;
      p_err_q   <= 1'b0;
    end else begin
      case (wb_q)
        WB_IDLE: begin
          if (bus.x_p_valid_i) begin
            p_rd_q    <= bus.x_p_rd_i;
            p_data0_q <= bus.x_p_data0_i;
            p_data1_q <= bus.x_p_data1_i;
            p_dual_q  <= bus.x_p_dual_i;
            p_err_q   <= bus.x_p_error_i;
            wb_q      <= WB_D0;
          end
        end
        WB_D0:   if (step_done) wb_q <= p_dual_q ? WB_D1 : WB_IDLE;
        WB_D1:   if (step_done) wb_q <= WB_IDLE;
        default: wb_q <= WB_IDLE;
      endcase
    end
  end

  assign bus.issue_ready_o   = issue_ready;
  assign bus.issue_accept_o  = accept_fire;
  assign bus.issue_illegal_o = handoff && !bus.x_k_accept_i;
  assign bus.x_q_valid_o     = (off_q == OFF_HOLD);
  assign bus.x_instr_o       = instr_q;
  assign bus.x_rs_o          = rs_q;
  assign bus.x_rs_valid_o    = rs_valid_q;
  assign bus.x_rd_clean_o[0] = (hold_rd == 5'd0)  || !pend_q[hold_rd];
  assign bus.x_rd_clean_o[1] = (hold_rd1 == 5'd0) || !pend_q[hold_rd1];
  assign bus.x_p_ready_o     = (wb_q == WB_IDLE);
  assign bus.wb_valid_o      = (wb_q != WB_IDLE) && !cur_is_x0;
  assign bus.wb_rd_o         = cur_rd;
  assign bus.wb_data_o       = (wb_q == WB_D1) ? p_data1_q : p_data0_q;
  assign bus.wb_error_o      = p_err_q && bus.wb_valid_o;
  assign bus.busy_o          = (off_q == OFF_HOLD) || (cnt_q != '0) || (wb_q != WB_IDLE);

endmodule

`default_nettype wire
